// File: rtl/cmac_axis_rate_monitor_pkg.sv
// Shared constants, per-channel snapshot record and saturating adder for the CMAC AXIS rate monitor.
package cmac_mon_pkg;

    localparam int unsigned DEF_WINDOW = 32'd322_266_000;
    localparam int          KEEP_W     = 64;
    localparam int          BYTE_CNT_W = 64;
    localparam int          EVT_CNT_W  = 32;
    localparam int          SAT_W      = 64;

    typedef logic [SAT_W-1:0] sat_t;

    typedef struct packed {
        logic [BYTE_CNT_W-1:0] bytes;
        logic [EVT_CNT_W-1:0]  frames;
        logic [EVT_CNT_W-1:0]  stalls;
        logic [BYTE_CNT_W-1:0] peak;
    } ch_stat_t;

    // a + b clamped to lim; operands are zero-extended counters no larger than lim
    function automatic sat_t sat_add(input sat_t a, input sat_t b, input sat_t lim);
        logic [SAT_W:0] sum;
        sat_t           res;
        sum = {1'b0, a} + {1'b0, b};
        res = (sum > {1'b0, lim}) ? lim : sum[SAT_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/cmac_axis_rate_monitor_chan.sv
// One channel: S1 registers beat popcount/flags, S2 accumulates and snapshots on end-of-window.
// Two-cycle latency from tap to snapshot; passive tap, never applies backpressure.
module cmac_mon_chan
    import cmac_mon_pkg::*;
#(
    parameter int KW = KEEP_W
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clear_i,
    input  logic          eow_s1_i,
    input  logic          tvalid_i,
    input  logic          tready_i,
    input  logic          tlast_i,
    input  logic [KW-1:0] tkeep_i,
    output ch_stat_t      stat_o
);

    localparam int   PC_W     = $clog2(KW + 1);
    localparam sat_t BYTE_MAX = sat_t'({BYTE_CNT_W{1'b1}});
    localparam sat_t EVT_MAX  = sat_t'({EVT_CNT_W{1'b1}});

    logic                  accept;
    logic [PC_W-1:0]       pop_d;
    logic [PC_W-1:0]       pop_q;
    logic                  frame_q;
    logic                  stall_q;
    logic [BYTE_CNT_W-1:0] acc_bytes_q;
    logic [EVT_CNT_W-1:0]  acc_frames_q;
    logic [EVT_CNT_W-1:0]  acc_stalls_q;
    logic [BYTE_CNT_W-1:0] snap_bytes_q;
    logic [EVT_CNT_W-1:0]  snap_frames_q;
    logic [EVT_CNT_W-1:0]  snap_stalls_q;
    logic [BYTE_CNT_W-1:0] peak_q;
    sat_t                  bytes_sum;
    sat_t                  frames_sum;
    sat_t                  stalls_sum;
    logic [BYTE_CNT_W-1:0] bytes_d;
    logic [EVT_CNT_W-1:0]  frames_d;
    logic [EVT_CNT_W-1:0]  stalls_d;
    logic [BYTE_CNT_W-1:0] peak_d;

    assign accept = tvalid_i & tready_i;

    always_comb begin
        pop_d = '0;
        for (int i = 0; i < KW; i++) begin
            pop_d = pop_d + PC_W'(tkeep_i[i]);
        end
    end

    always_comb begin
        bytes_sum  = sat_add(sat_t'(acc_bytes_q), sat_t'(pop_q), BYTE_MAX);
        frames_sum = sat_add(sat_t'(acc_frames_q), sat_t'(frame_q), EVT_MAX);
        stalls_sum = sat_add(sat_t'(acc_stalls_q), sat_t'(stall_q), EVT_MAX);
        bytes_d    = bytes_sum[BYTE_CNT_W-1:0];
        frames_d   = frames_sum[EVT_CNT_W-1:0];
        stalls_d   = stalls_sum[EVT_CNT_W-1:0];
        peak_d     = (bytes_d > peak_q) ? bytes_d : peak_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pop_q         <= '0;
            frame_q       <= 1'b0;
            stall_q       <= 1'b0;
            acc_bytes_q   <= '0;
            acc_frames_q  <= '0;
            acc_stalls_q  <= '0;
            snap_bytes_q  <= '0;
            snap_frames_q <= '0;
            snap_stalls_q <= '0;
            peak_q        <= '0;
        end else if (clear_i) begin
            pop_q         <= '0;
            frame_q       <= 1'b0;
            stall_q       <= 1'b0;
            acc_bytes_q   <= '0;
            acc_frames_q  <= '0;
            acc_stalls_q  <= '0;
            snap_bytes_q  <= '0;
            snap_frames_q <= '0;
            snap_stalls_q <= '0;
            peak_q        <= '0;
        end else begin
            // tkeep only matters on accepted beats
            pop_q   <= accept ? pop_d : '0;
            frame_q <= accept & tlast_i;
            stall_q <= tvalid_i & ~tready_i;
            if (eow_s1_i) begin
                snap_bytes_q  <= bytes_d;
                snap_frames_q <= frames_d;
                snap_stalls_q <= stalls_d;
                peak_q        <= peak_d;
                acc_bytes_q   <= '0;
                acc_frames_q  <= '0;
                acc_stalls_q  <= '0;
            end else begin
                acc_bytes_q  <= bytes_d;
                acc_frames_q <= frames_d;
                acc_stalls_q <= stalls_d;
            end
        end
    end

    assign stat_o.bytes  = snap_bytes_q;
    assign stat_o.frames = snap_frames_q;
    assign stat_o.stalls = snap_stalls_q;
    assign stat_o.peak   = peak_q;

endmodule

// File: rtl/cmac_axis_rate_monitor.sv
// Multi-channel AXIS throughput monitor: window counter, reset sync, snapshot valid/sequence.
// Snapshot appears two cycles after the last window cycle; passive tap with no backpressure.
module cmac_axis_rate_monitor #(
    parameter int          NUM_CH     = 4,
    parameter int          DATA_W     = 512,
    parameter int unsigned DEF_WINDOW = cmac_mon_pkg::DEF_WINDOW
) (
    input  logic                                      gt_clk,
    input  logic                                      sys_reset_n,
    input  logic [NUM_CH-1:0]                         mon_tvalid,
    input  logic [NUM_CH-1:0]                         mon_tready,
    input  logic [NUM_CH-1:0]                         mon_tlast,
    input  logic [NUM_CH*(DATA_W/8)-1:0]              mon_tkeep,
    input  logic [31:0]                               cfg_window_cycles,
    input  logic                                      cfg_clear,
    output logic                                      stat_valid,
    output logic [15:0]                               stat_seq,
    output logic [NUM_CH*cmac_mon_pkg::BYTE_CNT_W-1:0] stat_bytes,
    output logic [NUM_CH*cmac_mon_pkg::EVT_CNT_W-1:0]  stat_frames,
    output logic [NUM_CH*cmac_mon_pkg::EVT_CNT_W-1:0]  stat_stalls,
    output logic [NUM_CH*cmac_mon_pkg::BYTE_CNT_W-1:0] stat_peak_bytes
);

    import cmac_mon_pkg::*;

    localparam int KW = DATA_W / 8;

    logic        rst_meta_q;
    logic        rst_n_q;
    logic [31:0] win_cnt_q;
    logic [31:0] win_cnt_d;
    logic [31:0] len_q;
    logic [31:0] len_d;
    logic        eow;
    logic        eow_s1_q;
    logic        stat_valid_q;
    logic [15:0] stat_seq_q;

    always_ff @(posedge gt_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    // Window length is only re-sampled on the first cycle of each window
    always_comb begin
        len_d = len_q;
        if (win_cnt_q == '0) begin
            len_d = (cfg_window_cycles == '0) ? DEF_WINDOW : cfg_window_cycles;
        end
        eow       = (win_cnt_q == len_d - 32'd1);
        win_cnt_d = eow ? '0 : win_cnt_q + 32'd1;
    end

    always_ff @(posedge gt_clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            win_cnt_q    <= '0;
            len_q        <= '0;
            eow_s1_q     <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_seq_q   <= '0;
        end else if (cfg_clear) begin
            win_cnt_q    <= '0;
            len_q        <= '0;
            eow_s1_q     <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_seq_q   <= '0;
        end else begin
            win_cnt_q    <= win_cnt_d;
            len_q        <= len_d;
            eow_s1_q     <= eow;
            stat_valid_q <= eow_s1_q;
            if (eow_s1_q) begin
                stat_seq_q <= stat_seq_q + 16'd1;
            end
        end
    end

    assign stat_valid = stat_valid_q;
    assign stat_seq   = stat_seq_q;

    ch_stat_t ch_stat [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cmac_mon_chan #(
            .KW (KW)
        ) u_chan (
            .clk_i    (gt_clk),
            .rst_n_i  (rst_n_q),
            .clear_i  (cfg_clear),
            .eow_s1_i (eow_s1_q),
            .tvalid_i (mon_tvalid[c]),
            .tready_i (mon_tready[c]),
            .tlast_i  (mon_tlast[c]),
            .tkeep_i  (mon_tkeep[c*KW +: KW]),
            .stat_o   (ch_stat[c])
        );

        assign stat_bytes[c*BYTE_CNT_W +: BYTE_CNT_W]      = ch_stat[c].bytes;
        assign stat_frames[c*EVT_CNT_W +: EVT_CNT_W]       = ch_stat[c].frames;
        assign stat_stalls[c*EVT_CNT_W +: EVT_CNT_W]       = ch_stat[c].stalls;
        assign stat_peak_bytes[c*BYTE_CNT_W +: BYTE_CNT_W] = ch_stat[c].peak;
    end

endmodule
